question_reward: RTL and testbench

- Spawns and animates the reward released when a question block is emptied. The reward is a coin or a mushroom.
- Watches the block's empty flag, detects its rising edge, runs the reward sequence, and reports collection or score events to the game logic.
- Supplies a per-pixel hit flag and sprite ROM address to the colour mapper, in the same style as the other sprite blocks.
- One instance per question block; sits beside that block's instance in the top level.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/player_overlap.sv | 30 +++
 rtl/question_reward.sv | 180 ++++++++++++++++++
 tb/tb_question_reward.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite definitions: reward FSM states, sprite geometry and reward type codes.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    FALL,
    WALK,
    DONE
  } reward_state_t;

  localparam int unsigned SPRITE_W        = 20;
  localparam int unsigned OFFSCREEN_X     = 800;
  localparam int unsigned PLAYER_W        = 14;

  localparam int unsigned REWARD_COIN     = 0;
  localparam int unsigned REWARD_MUSHROOM = 1;

endpackage

// File: rtl/player_overlap.sv
// Combinational box test between one player and the reward sprite.
module player_overlap
  import sprite_pkg::*;
(
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] player_size_y,
  input  logic [1:0] health,
  input  logic [9:0] reward_x,
  input  logic [9:0] reward_y,
  output logic       hit
);

  logic [9:0] player_right;
  logic [9:0] player_top;
  logic [9:0] reward_right;
  logic [9:0] reward_bottom;

  // Player y is the feet row, so the head sits Size_Y above it.
  always_comb begin
    player_right  = player_x + 10'(PLAYER_W);
    player_top    = player_y - player_size_y;
    reward_right  = reward_x + 10'(SPRITE_W - 1);
    reward_bottom = reward_y + 10'(SPRITE_W - 1);
    hit = (health != 2'd0)
        && (player_right >= reward_x) && (player_x <= reward_right)
        && (player_y >= reward_y) && (player_top <= reward_bottom);
  end

endmodule

// File: rtl/question_reward.sv
// Coin or mushroom released by an emptied question block: spawn, animate,
// collect, and per-pixel render outputs for the colour mapper.
module question_reward
  import sprite_pkg::*;
#(
  parameter int unsigned REWARD_TYPE      = 0,
  parameter int unsigned RISE_FRAMES      = 20,
  parameter int unsigned COIN_FALL_FRAMES = 10,
  parameter int unsigned X_LIMIT          = 620
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [2:0] level_num,
  input  logic [2:0] reward_level_num,
  input  logic [9:0] block_x,
  input  logic [9:0] block_y,
  input  logic       is_question_empty,
  input  logic [9:0] mario_x,
  input  logic [9:0] mario_y,
  input  logic [9:0] luigi_x,
  input  logic [9:0] luigi_y,
  input  logic [9:0] mario_Size_Y,
  input  logic [9:0] luigi_Size_Y,
  input  logic [1:0] mario_health,
  input  logic [1:0] luigi_health,
  output logic       is_reward,
  output logic [8:0] reward_address,
  output logic       coin_pulse,
  output logic       grant_mario,
  output logic       grant_luigi,
  output logic       reward_active
);

  reward_state_t state, state_n;
  logic [9:0] reward_x, reward_x_n;
  logic [9:0] reward_y, reward_y_n;
  logic [9:0] counter, counter_n;
  logic       empty_prev;
  logic       coin_n, grant_mario_n, grant_luigi_n;
  logic       hit_mario, hit_luigi;
  logic       level_ok, trig;

  player_overlap u_mario_overlap (
    .player_x      (mario_x),
    .player_y      (mario_y),
    .player_size_y (mario_Size_Y),
    .health        (mario_health),
    .reward_x      (reward_x),
    .reward_y      (reward_y),
    .hit           (hit_mario)
  );

  player_overlap u_luigi_overlap (
    .player_x      (luigi_x),
    .player_y      (luigi_y),
    .player_size_y (luigi_Size_Y),
    .health        (luigi_health),
    .reward_x      (reward_x),
    .reward_y      (reward_y),
    .hit           (hit_luigi)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      reward_x    <= 10'(OFFSCREEN_X);
      reward_y    <= '0;
      counter     <= '0;
      empty_prev  <= 1'b0;
      coin_pulse  <= 1'b0;
      grant_mario <= 1'b0;
      grant_luigi <= 1'b0;
    end else begin
      state       <= state_n;
      reward_x    <= reward_x_n;
      reward_y    <= reward_y_n;
      counter     <= counter_n;
      empty_prev  <= is_question_empty;
      coin_pulse  <= coin_n;
      grant_mario <= grant_mario_n;
      grant_luigi <= grant_luigi_n;
    end
  end

  always_comb begin
    state_n       = state;
    reward_x_n    = reward_x;
    reward_y_n    = reward_y;
    counter_n     = counter;
    coin_n        = 1'b0;
    grant_mario_n = 1'b0;
    grant_luigi_n = 1'b0;
    level_ok      = (level_num == reward_level_num);
    trig          = is_question_empty & ~empty_prev & level_ok;

    case (state)
      IDLE: begin
        reward_x_n = 10'(OFFSCREEN_X);
        if (trig) begin
          reward_x_n = block_x;
          reward_y_n = block_y;
          counter_n  = '0;
          state_n    = RISE;
          coin_n     = (REWARD_TYPE == REWARD_COIN);
        end
      end
      RISE: begin
        if (!level_ok) begin
          state_n    = DONE;
          reward_x_n = 10'(OFFSCREEN_X);
        end else begin
          reward_y_n = reward_y - 10'd1;
          if (counter == 10'(RISE_FRAMES - 1)) begin
            counter_n = '0;
            state_n   = (REWARD_TYPE == REWARD_COIN) ? FALL : WALK;
          end else begin
            counter_n = counter + 10'd1;
          end
        end
      end
      FALL: begin
        if (!level_ok) begin
          state_n    = DONE;
          reward_x_n = 10'(OFFSCREEN_X);
        end else begin
          reward_y_n = reward_y + 10'd1;
          if (counter == 10'(COIN_FALL_FRAMES - 1)) begin
            state_n    = DONE;
            reward_x_n = 10'(OFFSCREEN_X);
          end else begin
            counter_n = counter + 10'd1;
          end
        end
      end
      WALK: begin
        // Collection is judged at the current position, before this frame's step; Mario has priority.
        if (!level_ok) begin
          state_n    = DONE;
          reward_x_n = 10'(OFFSCREEN_X);
        end else if (hit_mario) begin
          grant_mario_n = 1'b1;
          state_n       = DONE;
          reward_x_n    = 10'(OFFSCREEN_X);
        end else if (hit_luigi) begin
          grant_luigi_n = 1'b1;
          state_n       = DONE;
          reward_x_n    = 10'(OFFSCREEN_X);
        end else if (reward_x >= 10'(X_LIMIT)) begin
          state_n    = DONE;
          reward_x_n = 10'(OFFSCREEN_X);
        end else begin
          reward_x_n = reward_x + 10'd1;
        end
      end
      DONE: begin
        reward_x_n = 10'(OFFSCREEN_X);
      end
      default: begin
        state_n    = IDLE;
        reward_x_n = 10'(OFFSCREEN_X);
      end
    endcase
  end

  logic [9:0] dx, dy, addr_full;

  always_comb begin
    reward_active = (state == RISE) || (state == FALL) || (state == WALK);
    dx            = DrawX - reward_x;
    dy            = DrawY - reward_y;
    is_reward     = reward_active
                 && (DrawX >= reward_x) && (DrawX <= reward_x + 10'(SPRITE_W - 1))
                 && (DrawY >= reward_y) && (DrawY <= reward_y + 10'(SPRITE_W - 1));
    addr_full      = dx + dy * 10'(SPRITE_W);
    reward_address = is_reward ? 9'(addr_full) : '0;
  end

endmodule

// File: tb/tb_question_reward.sv
// Directed bench for question_reward: one coin instance and one mushroom instance.
module tb_question_reward;

  logic       Reset;
  logic       frame_clk = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic [2:0] level_num, reward_level_num;
  logic [9:0] block_x, block_y;
  logic       empty_c, empty_m;
  logic [9:0] mario_x, mario_y, luigi_x, luigi_y, mario_Size_Y, luigi_Size_Y;
  logic [1:0] mario_health, luigi_health;

  logic       is_reward_c, coin_c, gm_c, gl_c, act_c;
  logic [8:0] addr_c;
  logic       is_reward_m, coin_m, gm_m, gl_m, act_m;
  logic [8:0] addr_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 frame_clk = ~frame_clk;

  question_reward #(.REWARD_TYPE(0), .RISE_FRAMES(20), .COIN_FALL_FRAMES(10), .X_LIMIT(620)) dut_coin (
    .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .level_num(level_num), .reward_level_num(reward_level_num),
    .block_x(block_x), .block_y(block_y), .is_question_empty(empty_c),
    .mario_x(mario_x), .mario_y(mario_y), .luigi_x(luigi_x), .luigi_y(luigi_y),
    .mario_Size_Y(mario_Size_Y), .luigi_Size_Y(luigi_Size_Y),
    .mario_health(mario_health), .luigi_health(luigi_health),
    .is_reward(is_reward_c), .reward_address(addr_c), .coin_pulse(coin_c),
    .grant_mario(gm_c), .grant_luigi(gl_c), .reward_active(act_c)
  );

  question_reward #(.REWARD_TYPE(1), .RISE_FRAMES(20), .COIN_FALL_FRAMES(10), .X_LIMIT(620)) dut_mush (
    .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .level_num(level_num), .reward_level_num(reward_level_num),
    .block_x(block_x), .block_y(block_y), .is_question_empty(empty_m),
    .mario_x(mario_x), .mario_y(mario_y), .luigi_x(luigi_x), .luigi_y(luigi_y),
    .mario_Size_Y(mario_Size_Y), .luigi_Size_Y(luigi_Size_Y),
    .mario_health(mario_health), .luigi_health(luigi_health),
    .is_reward(is_reward_m), .reward_address(addr_m), .coin_pulse(coin_m),
    .grant_mario(gm_m), .grant_luigi(gl_m), .reward_active(act_m)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic probe(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
  endtask

  // Pins the sprite's top-left corner at (x,y) through the render outputs.
  task automatic check_corner(input string tag, input bit mush, input int x, input int y);
    probe(x, y);
    check_eq({tag, "_in"}, mush ? is_reward_m : is_reward_c, 1);
    check_eq({tag, "_addr0"}, mush ? addr_m : addr_c, 0);
    probe(x, y - 1);
    check_eq({tag, "_above"}, mush ? is_reward_m : is_reward_c, 0);
    probe(x - 1, y);
    check_eq({tag, "_left"}, mush ? is_reward_m : is_reward_c, 0);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
  endtask

  task automatic rise_mush();
    empty_m = 1'b0;
    pulse_reset();
    tick();
    empty_m = 1'b1;
    tick();
    check_eq("mush_no_coin", coin_m, 0);
    check_eq("mush_active", act_m, 1);
    repeat (20) tick();
    check_corner("mush_top", 1'b1, 200, 280);
  endtask

  task automatic walk_until(input int limit, output int n);
    n = 0;
    while (n < limit && act_m && !gm_m && !gl_m) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    Reset = 1'b1;
    DrawX = '0; DrawY = '0;
    level_num = 3'd1; reward_level_num = 3'd1;
    block_x = 10'd200; block_y = 10'd300;
    empty_c = 1'b0; empty_m = 1'b0;
    mario_x = 10'd0; mario_y = 10'd0; mario_Size_Y = 10'd20; mario_health = 2'd0;
    luigi_x = 10'd0; luigi_y = 10'd0; luigi_Size_Y = 10'd20; luigi_health = 2'd0;
    repeat (2) tick();

    // Reset state
    probe(800, 0);
    check_eq("rst_active_c", act_c, 0);
    check_eq("rst_active_m", act_m, 0);
    check_eq("rst_coin", coin_c, 0);
    check_eq("rst_grants", {gm_m, gl_m}, 0);
    check_eq("rst_is_reward", is_reward_c, 0);
    check_eq("rst_addr", addr_c, 0);
    Reset = 1'b0;
    tick();

    // Coin: spawn, one-frame pulse, rise 20, fall 10, done
    empty_c = 1'b1;
    tick();
    check_eq("coin_pulse_hi", coin_c, 1);
    check_eq("coin_active", act_c, 1);
    check_corner("coin_spawn", 1'b0, 200, 300);
    tick();
    check_eq("coin_pulse_lo", coin_c, 0);
    repeat (9) tick();
    probe(205, 293);
    check_eq("render_in", is_reward_c, 1);
    check_eq("render_addr65", addr_c, 65);
    probe(220, 293);
    check_eq("render_out", is_reward_c, 0);
    check_eq("render_out_addr", addr_c, 0);
    repeat (10) tick();
    check_corner("coin_top", 1'b0, 200, 280);
    check_eq("coin_fall_active", act_c, 1);
    repeat (9) tick();
    check_corner("coin_fall9", 1'b0, 200, 289);
    tick();
    check_eq("coin_done_active", act_c, 0);
    probe(200, 290);
    check_eq("coin_done_hidden", is_reward_c, 0);
    check_eq("coin_done_pulse", coin_c, 0);
    empty_c = 1'b0;
    tick();
    empty_c = 1'b1;
    tick();
    check_eq("coin_retrig_active", act_c, 0);
    check_eq("coin_retrig_pulse", coin_c, 0);
    empty_c = 1'b0;

    // Mushroom walks into a standing Mario: grant at x = 211, walk frame 12
    mario_x = 10'd230; mario_y = 10'd299; mario_health = 2'd1;
    rise_mush();
    walk_until(100, n);
    check_eq("mario_grant_frame", n, 12);
    check_eq("mario_grant", gm_m, 1);
    check_eq("mario_grant_luigi", gl_m, 0);
    check_eq("mario_grant_done", act_m, 0);
    tick();
    check_eq("mario_grant_once", gm_m, 0);
    probe(211, 280);
    check_eq("mario_offscreen", is_reward_m, 0);

    // Both overlap: Mario wins; Reset drops the pulse at once
    luigi_x = 10'd230; luigi_y = 10'd299; luigi_health = 2'd1;
    rise_mush();
    walk_until(100, n);
    check_eq("both_frame", n, 12);
    check_eq("both_mario", gm_m, 1);
    check_eq("both_luigi", gl_m, 0);
    Reset = 1'b1;
    #1;
    check_eq("reset_drops_grant", gm_m, 0);
    Reset = 1'b0;

    // Mario dead: Luigi collects
    mario_health = 2'd0;
    rise_mush();
    walk_until(100, n);
    check_eq("luigi_frame", n, 12);
    check_eq("luigi_grant", gl_m, 1);
    check_eq("luigi_mario", gm_m, 0);

    // Both dead: walk to X_LIMIT, despawn without pulses
    luigi_health = 2'd0;
    rise_mush();
    n = 0;
    pulses = 0;
    while (n < 500 && act_m) begin
      tick();
      n++;
      if (gm_m || gl_m || coin_m) pulses++;
    end
    check_eq("limit_frames", n, 421);
    check_eq("limit_pulses", pulses, 0);

    // Level mismatch
    empty_c = 1'b0; empty_m = 1'b0;
    pulse_reset();
    tick();
    level_num = 3'd2;
    empty_c = 1'b1; empty_m = 1'b1;
    tick();
    check_eq("lvl_idle_c", act_c, 0);
    check_eq("lvl_idle_m", act_m, 0);
    check_eq("lvl_idle_pulse", coin_c, 0);
    level_num = 3'd1;
    empty_c = 1'b0;
    tick();
    empty_c = 1'b1;
    tick();
    check_eq("lvl_trig_pulse", coin_c, 1);
    repeat (5) tick();
    level_num = 3'd2;
    tick();
    check_eq("lvl_leave_active", act_c, 0);
    check_eq("lvl_leave_pulse", coin_c, 0);
    level_num = 3'd1;
    empty_c = 1'b0;
    tick();
    empty_c = 1'b1;
    tick();
    check_eq("lvl_retrig_active", act_c, 0);
    check_eq("lvl_retrig_pulse", coin_c, 0);

    // Asynchronous reset in the middle of WALK
    rise_mush();
    repeat (5) tick();
    check_corner("walk5", 1'b1, 205, 280);
    probe(205, 280);
    #1;
    Reset = 1'b1;
    #1;
    check_eq("async_rst_active", act_m, 0);
    check_eq("async_rst_render", is_reward_m, 0);
    check_eq("async_rst_addr", addr_m, 0);
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
